// File: rtl/scan_line_buffer.sv
// Line-capture buffer: packs stream samples into RAM words; s1 read and CSR read both return 1 cycle later.
// snk_ready is high only while capturing, s1 never stalls; define SCAN_TIMESTAMP_EN for T_START/T_END (CSR 4/5).
module scan_line_buffer #(
  parameter int DATA_W   = 32,
  parameter int DEPTH    = 128,
  parameter int ADDR_W   = 7,
  parameter int SAMPLE_W = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic [ADDR_W-1:0]     s1_address,
  input  logic                  s1_chipselect,
  input  logic                  s1_read,
  input  logic                  s1_write,
  input  logic [DATA_W/8-1:0]   s1_byteenable,
  input  logic [DATA_W-1:0]     s1_writedata,
  output logic [DATA_W-1:0]     s1_readdata,
  output logic                  s1_readdatavalid,
  input  logic [2:0]            csr_address,
  input  logic                  csr_read,
  input  logic                  csr_write,
  input  logic [31:0]           csr_writedata,
  output logic [31:0]           csr_readdata,
  input  logic                  snk_valid,
  input  logic [SAMPLE_W-1:0]   snk_data,
  input  logic                  snk_eol,
  output logic                  snk_ready,
  output logic                  irq
);

  localparam int PACK   = DATA_W / SAMPLE_W;
  localparam int PCNT_W = (PACK > 1) ? $clog2(PACK) : 1;
  localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int BE_W   = DATA_W / 8;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_CAPTURE = 2'd1;
  localparam logic [1:0] ST_FLUSH   = 2'd2;
  localparam logic [1:0] ST_DONE    = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [DATA_W-1:0] pack_q, pack_d;
  logic [PCNT_W-1:0] pcnt_q, pcnt_d;
  logic [31:0]       word_cnt_q, word_cnt_d;
  logic [31:0]       sample_cnt_q, sample_cnt_d;
  logic              wrap_q, wrap_d;
  logic              irq_en_q, irq_en_d;
  logic              done_q, done_d;
  logic              ovf_q, ovf_d;

  logic              start_req, start_take, accept, ptr_last;
  logic              cap_we;
  logic [DATA_W-1:0] cap_wdata, word_mix;
  logic [31:0]       csr_mux;
  logic [31:0]       t_start_val, t_end_val;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;
  logic              rdv_q;
  logic [31:0]       csr_rdata_q;

  logic              s1_rd, s1_wr_ok, s1_in_range;
  logic [IDX_W-1:0]  s1_idx, cap_idx;
  logic              unused_csr_bits;

  assign unused_csr_bits = ^csr_writedata[31:3];

  always_comb begin
    state_d      = state_q;
    wr_ptr_d     = wr_ptr_q;
    pack_d       = pack_q;
    pcnt_d       = pcnt_q;
    word_cnt_d   = word_cnt_q;
    sample_cnt_d = sample_cnt_q;
    wrap_d       = wrap_q;
    irq_en_d     = irq_en_q;
    done_d       = done_q;
    ovf_d        = ovf_q;
    cap_we       = 1'b0;
    cap_wdata    = pack_q;

    start_req  = csr_write && (csr_address == 3'd0) && csr_writedata[0];
    start_take = start_req && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    accept     = snk_valid && (state_q == ST_CAPTURE);
    ptr_last   = (wr_ptr_q == ADDR_W'(DEPTH - 1));
    // pack_q is zero above the filled lanes, so OR-ing in the new sample is enough
    word_mix   = pack_q | (DATA_W'(snk_data) << (int'(pcnt_q) * SAMPLE_W));

    if (csr_write && (csr_address == 3'd0)) begin
      wrap_d   = csr_writedata[1];
      irq_en_d = csr_writedata[2];
    end
    if (csr_write && (csr_address == 3'd1)) begin
      if (csr_writedata[1]) done_d = 1'b0;
      if (csr_writedata[2]) ovf_d  = 1'b0;
    end

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start_take) begin
          state_d      = ST_CAPTURE;
          wr_ptr_d     = '0;
          pack_d       = '0;
          pcnt_d       = '0;
          word_cnt_d   = '0;
          sample_cnt_d = '0;
          done_d       = 1'b0;
          ovf_d        = 1'b0;
        end
      end
      ST_CAPTURE: begin
        if (accept) begin
          if (sample_cnt_q != '1) sample_cnt_d = sample_cnt_q + 32'd1;
          if (pcnt_q == PCNT_W'(PACK - 1)) begin
            cap_we    = 1'b1;
            cap_wdata = word_mix;
            pack_d    = '0;
            pcnt_d    = '0;
            if (snk_eol) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
            end
          end else begin
            pack_d = word_mix;
            pcnt_d = pcnt_q + 1'b1;
            if (snk_eol) state_d = ST_FLUSH;
          end
        end
      end
      ST_FLUSH: begin
        cap_we    = 1'b1;
        cap_wdata = pack_q;
        pack_d    = '0;
        pcnt_d    = '0;
        state_d   = ST_DONE;
        done_d    = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (cap_we) begin
      word_cnt_d = word_cnt_q + 32'd1;
      wr_ptr_d   = ptr_last ? '0 : wr_ptr_q + 1'b1;
      if (ptr_last) begin
        ovf_d = 1'b1;
        if (!wrap_q && (state_q == ST_CAPTURE)) begin
          state_d = ST_DONE;
          done_d  = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_IDLE;
      wr_ptr_q     <= '0;
      pack_q       <= '0;
      pcnt_q       <= '0;
      word_cnt_q   <= '0;
      sample_cnt_q <= '0;
      wrap_q       <= 1'b0;
      irq_en_q     <= 1'b0;
      done_q       <= 1'b0;
      ovf_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      wr_ptr_q     <= wr_ptr_d;
      pack_q       <= pack_d;
      pcnt_q       <= pcnt_d;
      word_cnt_q   <= word_cnt_d;
      sample_cnt_q <= sample_cnt_d;
      wrap_q       <= wrap_d;
      irq_en_q     <= irq_en_d;
      done_q       <= done_d;
      ovf_q        <= ovf_d;
    end
  end

`ifdef SCAN_TIMESTAMP_EN
  logic [31:0] ts_q, t_start_q, t_end_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ts_q      <= '0;
      t_start_q <= '0;
      t_end_q   <= '0;
    end else begin
      ts_q <= ts_q + 32'd1;
      if (start_take) t_start_q <= ts_q;
      if ((state_d == ST_DONE) && (state_q != ST_DONE)) t_end_q <= ts_q;
    end
  end

  assign t_start_val = t_start_q;
  assign t_end_val   = t_end_q;
`else
  assign t_start_val = '0;
  assign t_end_val   = '0;
`endif

  always_comb begin
    csr_mux = '0;
    case (csr_address)
      3'd0:    csr_mux = {29'd0, irq_en_q, wrap_q, 1'b0};
      3'd1:    csr_mux = {29'd0, ovf_q, done_q, (state_q == ST_CAPTURE) || (state_q == ST_FLUSH)};
      3'd2:    csr_mux = word_cnt_q;
      3'd3:    csr_mux = sample_cnt_q;
      3'd4:    csr_mux = t_start_val;
      3'd5:    csr_mux = t_end_val;
      default: csr_mux = '0;
    endcase
  end

  assign s1_rd       = s1_chipselect && s1_read;
  assign s1_in_range = (32'(s1_address) < DEPTH);
  assign s1_idx      = s1_address[IDX_W-1:0];
  assign cap_idx     = wr_ptr_q[IDX_W-1:0];
  // capture owns the word on an address collision
  assign s1_wr_ok    = s1_chipselect && s1_write && s1_in_range &&
                       !(cap_we && (s1_address == wr_ptr_q));

  always_ff @(posedge clk) begin
    if (cap_we) mem[cap_idx] <= cap_wdata;
    if (s1_wr_ok) begin
      for (int b = 0; b < BE_W; b++) begin
        if (s1_byteenable[b]) mem[s1_idx][b*8 +: 8] <= s1_writedata[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rdata_q     <= '0;
      rdv_q       <= 1'b0;
      csr_rdata_q <= '0;
    end else begin
      rdv_q <= s1_rd;
      if (s1_rd) rdata_q <= s1_in_range ? mem[s1_idx] : '0;
      if (csr_read) csr_rdata_q <= csr_mux;
    end
  end

  assign s1_readdata      = rdata_q;
  assign s1_readdatavalid = rdv_q;
  assign csr_readdata     = csr_rdata_q;
  assign snk_ready        = (state_q == ST_CAPTURE);
  assign irq              = done_q & irq_en_q;

endmodule

// File: tb/tb_scan_line_buffer.sv
// Bench for scan_line_buffer (DEPTH=4, PACK=4); s1 reads are checked through a scoreboard queue.
module tb_scan_line_buffer;
  localparam int DW = 32;
  localparam int DEP = 4;
  localparam int AW = 2;
  localparam int SW = 8;

  logic          clk;
  logic          reset_n;
  logic [AW-1:0] s1_address;
  logic          s1_chipselect, s1_read, s1_write;
  logic [DW/8-1:0] s1_byteenable;
  logic [DW-1:0] s1_writedata, s1_readdata;
  logic          s1_readdatavalid;
  logic [2:0]    csr_address;
  logic          csr_read, csr_write;
  logic [31:0]   csr_writedata, csr_readdata;
  logic          snk_valid, snk_eol, snk_ready, irq;
  logic [SW-1:0] snk_data;

  scan_line_buffer #(.DATA_W(DW), .DEPTH(DEP), .ADDR_W(AW), .SAMPLE_W(SW)) dut (
    .clk(clk), .reset_n(reset_n),
    .s1_address(s1_address), .s1_chipselect(s1_chipselect), .s1_read(s1_read),
    .s1_write(s1_write), .s1_byteenable(s1_byteenable), .s1_writedata(s1_writedata),
    .s1_readdata(s1_readdata), .s1_readdatavalid(s1_readdatavalid),
    .csr_address(csr_address), .csr_read(csr_read), .csr_write(csr_write),
    .csr_writedata(csr_writedata), .csr_readdata(csr_readdata),
    .snk_valid(snk_valid), .snk_data(snk_data), .snk_eol(snk_eol), .snk_ready(snk_ready),
    .irq(irq)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  int last_wr_cyc = 0;
  int acc_cyc = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  int          cyc_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (s1_readdatavalid) begin
      if (exp_q.size() == 0) begin
        check("sb_rdv_unexpected", 32'(s1_readdatavalid), 32'd0);
      end else begin
        check(tag_q.pop_front(), s1_readdata, exp_q.pop_front());
        check("rdv_latency", 32'(cyc - cyc_q.pop_front()), 32'd1);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic csr_wr(input logic [2:0] a, input logic [31:0] d);
    csr_address = a; csr_writedata = d; csr_write = 1'b1;
    tick();
    csr_write = 1'b0;
    last_wr_cyc = cyc;
  endtask

  task automatic csr_get(input logic [2:0] a, output logic [31:0] v);
    csr_address = a; csr_read = 1'b1;
    tick();
    csr_read = 1'b0;
    v = csr_readdata;
  endtask

  task automatic csr_rd(input logic [2:0] a, input logic [31:0] exp, input string tag);
    logic [31:0] v;
    csr_get(a, v);
    check(tag, v, exp);
  endtask

  task automatic push_exp(input logic [31:0] exp, input string tag);
    exp_q.push_back(exp); tag_q.push_back(tag); cyc_q.push_back(cyc);
  endtask

  task automatic s1_rd(input logic [AW-1:0] a, input logic [31:0] exp, input string tag);
    s1_address = a; s1_chipselect = 1'b1; s1_read = 1'b1;
    push_exp(exp, tag);
    tick();
    s1_read = 1'b0; s1_chipselect = 1'b0;
  endtask

  task automatic s1_wr(input logic [AW-1:0] a, input logic [31:0] d, input logic [3:0] be);
    s1_address = a; s1_chipselect = 1'b1; s1_write = 1'b1; s1_writedata = d; s1_byteenable = be;
    tick();
    s1_write = 1'b0; s1_chipselect = 1'b0;
  endtask

  task automatic send(input logic [7:0] d, input logic eol, output logic acc);
    snk_data = d; snk_eol = eol; snk_valid = 1'b1; acc = 1'b0;
    for (int i = 0; i < 4 && !acc; i++) begin
      @(negedge clk);
      if (snk_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    snk_valid = 1'b0; snk_eol = 1'b0;
    if (acc) acc_cyc = cyc;
  endtask

  // sample accepted in the same cycle as an s1 read or write (capture must be running)
  task automatic send_s1(input logic [7:0] d, input logic rd, input logic [AW-1:0] a,
                         input logic [31:0] wd, input logic [31:0] rexp, input string tag);
    check({tag, "_rdy"}, 32'(snk_ready), 32'd1);
    snk_data = d; snk_eol = 1'b0; snk_valid = 1'b1;
    s1_address = a; s1_chipselect = 1'b1; s1_read = rd; s1_write = !rd;
    s1_writedata = wd; s1_byteenable = 4'hF;
    if (rd) push_exp(rexp, tag);
    tick();
    snk_valid = 1'b0; s1_chipselect = 1'b0; s1_read = 1'b0; s1_write = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic acc;
    int   n;
    int   start_cyc;
    logic [31:0] ts0, ts1;
    reset_n = 1'b0;
    s1_address = '0; s1_chipselect = 0; s1_read = 0; s1_write = 0;
    s1_byteenable = '0; s1_writedata = '0;
    csr_address = '0; csr_read = 0; csr_write = 0; csr_writedata = '0;
    snk_valid = 0; snk_data = '0; snk_eol = 0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_readdata", s1_readdata, 32'd0);
    check("rst_rdv", 32'(s1_readdatavalid), 32'd0);
    check("rst_csr_rd", csr_readdata, 32'd0);
    check("rst_rdy", 32'(snk_ready), 32'd0);
    check("rst_irq", 32'(irq), 32'd0);
    reset_n = 1'b1;
    tick();
    csr_rd(3'd0, 32'd0, "rst_ctrl");
    csr_rd(3'd1, 32'd0, "rst_status");
    csr_rd(3'd2, 32'd0, "rst_wc");
    csr_rd(3'd3, 32'd0, "rst_sc");
    csr_rd(3'd6, 32'd0, "rsvd6");

    // T1: two full words, eol on a word boundary
    csr_wr(3'd0, 32'h1);
    start_cyc = last_wr_cyc;
    n = 0;
    for (int i = 0; i < 8; i++) begin
      send(8'(i + 1), i == 7, acc);
      if (acc) n++;
    end
    csr_rd(3'd1, 32'h2, "t1_status_noflush");
    check("t1_acc", 32'(n), 32'd8);
    s1_rd(2'd0, 32'h04030201, "t1_ram0");
    s1_rd(2'd1, 32'h08070605, "t1_ram1");
    csr_rd(3'd2, 32'd2, "t1_wc");
    csr_rd(3'd3, 32'd8, "t1_sc");
    check("t1_irq_off", 32'(irq), 32'd0);
`ifdef SCAN_TIMESTAMP_EN
    csr_get(3'd4, ts0);
    csr_get(3'd5, ts1);
    check("ts_delta", ts1 - ts0, 32'(acc_cyc - start_cyc));
`endif

    // T2: partial last word goes through FLUSH
    csr_wr(3'd0, 32'h5);
    for (int i = 0; i < 5; i++) send(8'hA1 + 8'(i), i == 4, acc);
    csr_rd(3'd1, 32'h1, "t2_status_flush");
    csr_rd(3'd1, 32'h2, "t2_status_done");
    s1_rd(2'd0, 32'hA4A3A2A1, "t2_ram0");
    s1_rd(2'd1, 32'h000000A5, "t2_ram1");
    csr_rd(3'd2, 32'd2, "t2_wc");
    csr_rd(3'd3, 32'd5, "t2_sc");
    check("t2_irq_on", 32'(irq), 32'd1);
    csr_rd(3'd0, 32'h4, "t2_ctrl");
    csr_wr(3'd1, 32'h2);
    check("t2_irq_w1c", 32'(irq), 32'd0);
    csr_rd(3'd1, 32'h0, "t2_status_cleared");

    // T3: overflow without wrap stops after DEPTH words
    csr_wr(3'd0, 32'h1);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      send(8'(i + 1), 1'b0, acc);
      if (acc) n++;
      if (i == 15) check("t3_rdy_drop", 32'(snk_ready), 32'd0);
    end
    check("t3_acc", 32'(n), 32'd16);
    csr_rd(3'd1, 32'h6, "t3_status");
    csr_rd(3'd2, 32'd4, "t3_wc");
    csr_rd(3'd3, 32'd16, "t3_sc");
    s1_rd(2'd3, 32'h100F0E0D, "t3_ram3");

    // T3b: wrap enabled, capture continues into word 0
    csr_wr(3'd0, 32'h3);
    n = 0;
    for (int i = 0; i < 20; i++) begin
      send(8'(i + 1), 1'b0, acc);
      if (acc) n++;
    end
    check("t3w_acc", 32'(n), 32'd20);
    check("t3w_rdy", 32'(snk_ready), 32'd1);
    csr_rd(3'd1, 32'h5, "t3w_status");
    csr_rd(3'd2, 32'd5, "t3w_wc");
    csr_rd(3'd3, 32'd20, "t3w_sc");
    s1_rd(2'd0, 32'h14131211, "t3w_ram0");

    // T4: read during capture write sees old data; capture wins a write collision
    for (int i = 0; i < 3; i++) send(8'h21 + 8'(i), 1'b0, acc);
    send_s1(8'h24, 1'b1, 2'd1, 32'h0, 32'h08070605, "t4_rd_old");
    for (int i = 0; i < 3; i++) send(8'h31 + 8'(i), 1'b0, acc);
    send_s1(8'h34, 1'b0, 2'd2, 32'hDEADBEEF, 32'h0, "t4_wr_coll");
    s1_rd(2'd2, 32'h34333231, "t4_collision");
    s1_rd(2'd1, 32'h24232221, "t4_ram1");
    send(8'h41, 1'b1, acc);
    tick();
    csr_rd(3'd2, 32'd8, "t4_wc");
    s1_rd(2'd3, 32'h00000041, "t4_flush");

    // T5: byte-enable merge
    s1_wr(2'd0, 32'hFFFFFFFF, 4'hF);
    s1_wr(2'd0, 32'h11223344, 4'b0101);
    s1_rd(2'd0, 32'hFF22FF44, "t5_be");

    // T6: reset mid-capture
    csr_wr(3'd0, 32'h1);
    send(8'h51, 1'b0, acc);
    send(8'h52, 1'b0, acc);
    check("t6_rdy_pre", 32'(snk_ready), 32'd1);
    #2;
    reset_n = 1'b0;
    #1;
    check("t6_rdy", 32'(snk_ready), 32'd0);
    check("t6_readdata", s1_readdata, 32'd0);
    check("t6_csr_rd", csr_readdata, 32'd0);
    check("t6_irq", 32'(irq), 32'd0);
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    tick();
    csr_rd(3'd1, 32'd0, "t6_status");
    csr_rd(3'd3, 32'd0, "t6_sc");
    csr_wr(3'd0, 32'h1);
    for (int i = 0; i < 4; i++) send(8'h61 + 8'(i), 1'b0, acc);
    s1_rd(2'd0, 32'h64636261, "t6_no_stale_partial");

    repeat (3) tick();
    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
